song_sequencer: RTL

//  Plays one song from the song table as a timed note stream for the buzzer/tone generator.

---
 rtl/song_pkg.sv | 52 +++++
 rtl/song_rom.sv | 54 +++++
 rtl/song_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/song_pkg.sv
// Shared widths, FSM encoding and note-entry payload for the song sequencer.
// Also holds the helper that turns a length/full_note pair into 1/16-note units.
package song_pkg;

  localparam int unsigned OCTAVE_BITS     = 3;
  localparam int unsigned NOTE_BITS       = 4;
  localparam int unsigned LENGTH_BITS     = 4;
  localparam int unsigned FULL_NOTE_BITS  = 3;
  localparam int unsigned SONG_BITS       = 2;
  localparam int unsigned SONG_CNT_BITS   = 4;
  localparam int unsigned MAX_FULL_NOTE   = 4;
  localparam int unsigned UNITS_PER_WHOLE = 16;
  localparam int unsigned UNITS_W         = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_GAP,
    ST_ADV
  } state_t;

  typedef struct packed {
    logic [OCTAVE_BITS-1:0]    octave;
    logic [NOTE_BITS-1:0]      note;
    logic [LENGTH_BITS-1:0]    length;
    logic [FULL_NOTE_BITS-1:0] full_note;
  } note_t;

  localparam int unsigned NOTE_ENTRY_W = $bits(note_t);

  function automatic note_t make_note(input logic [OCTAVE_BITS-1:0]    o,
                                      input logic [NOTE_BITS-1:0]      n,
                                      input logic [LENGTH_BITS-1:0]    l,
                                      input logic [FULL_NOTE_BITS-1:0] f);
    note_t e;
    e.octave    = o;
    e.note      = n;
    e.length    = l;
    e.full_note = f;
    return e;
  endfunction

  // full_note above MAX_FULL_NOTE saturates to a 1/16 note.
  function automatic logic [UNITS_W-1:0] note_units(input logic [LENGTH_BITS-1:0]    len,
                                                   input logic [FULL_NOTE_BITS-1:0] fn);
    logic [FULL_NOTE_BITS-1:0] f;
    f = (fn > FULL_NOTE_BITS'(MAX_FULL_NOTE)) ? FULL_NOTE_BITS'(MAX_FULL_NOTE) : fn;
    return (UNITS_W'(len) + UNITS_W'(1)) * (UNITS_W'(UNITS_PER_WHOLE) >> f);
  endfunction

endpackage

// File: rtl/song_rom.sv
// Combinational song table: {song, note index} -> track length and note entry.
module song_rom
  import song_pkg::*;
#(
  parameter int unsigned SONG_W = SONG_BITS,
  parameter int unsigned CNT_W  = SONG_CNT_BITS
) (
  input  logic [SONG_W-1:0]       i_song,
  input  logic [CNT_W-1:0]        i_cnt,
  output logic [CNT_W-1:0]        o_track_c,
  output logic [NOTE_ENTRY_W-1:0] o_entry_c
);

  note_t w_entry;

  always_comb begin
    w_entry   = '0;
    o_track_c = '0;
    case (i_song)
      SONG_W'(1): begin
        o_track_c = CNT_W'(3);
        case (i_cnt)
          CNT_W'(0): w_entry = make_note(3'd4, 4'd0, 4'd0, 3'd4);
          CNT_W'(1): w_entry = make_note(3'd4, 4'd2, 4'd0, 3'd4);
          CNT_W'(2): w_entry = make_note(3'd4, 4'd4, 4'd0, 3'd4);
          default:   w_entry = '0;
        endcase
      end
      SONG_W'(2): begin
        o_track_c = CNT_W'(2);
        case (i_cnt)
          CNT_W'(0): w_entry = make_note(3'd5, 4'd7, 4'd1, 3'd7);
          CNT_W'(1): w_entry = make_note(3'd3, 4'd9, 4'd1, 3'd4);
          default:   w_entry = '0;
        endcase
      end
      SONG_W'(3): begin
        o_track_c = CNT_W'(2);
        case (i_cnt)
          CNT_W'(0): w_entry = make_note(3'd2, 4'd11, 4'd0, 3'd3);
          CNT_W'(1): w_entry = make_note(3'd6, 4'd1, 4'd1, 3'd2);
          default:   w_entry = '0;
        endcase
      end
      default: begin
        o_track_c = '0;
        w_entry   = '0;
      end
    endcase
  end

  assign o_entry_c = w_entry;

endmodule

// File: rtl/song_sequencer.sv
// Plays one song from song_rom as a timed note stream with play/pause/stop,
// optional looping and a silent articulation gap at the end of every note.
module song_sequencer
  import song_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned UNIT_TICKS = 25,
  parameter int unsigned GAP_TICKS  = 3,
  parameter int unsigned SONG_W     = SONG_BITS,
  parameter int unsigned CNT_W      = SONG_CNT_BITS
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [SONG_W-1:0]      i_song_sel,
  input  logic                   i_start,
  input  logic                   i_pause,
  input  logic                   i_stop,
  input  logic                   i_loop_en,
  output logic [OCTAVE_BITS-1:0] o_octave,
  output logic [NOTE_BITS-1:0]   o_note,
  output logic                   o_sounding,
  output logic [CNT_W-1:0]       o_note_idx,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam int unsigned DUR_W = $clog2(UNITS_PER_WHOLE * UNITS_PER_WHOLE * UNIT_TICKS + 1);
  // Legato notes skip the gap and advance straight from PLAY.
  localparam state_t PLAY_END = (GAP_TICKS == 0) ? ST_ADV : ST_GAP;

  state_t                   r_state, w_state_nxt;
  logic [PRE_W-1:0]         r_presc, w_presc_nxt;
  logic [DUR_W-1:0]         r_dur, w_dur_nxt;
  logic [SONG_W-1:0]        r_song, w_song_nxt;
  logic [CNT_W-1:0]         r_idx, w_idx_nxt;
  logic [OCTAVE_BITS-1:0]   r_octave, w_octave_nxt;
  logic [NOTE_BITS-1:0]     r_note, w_note_nxt;
  logic                     r_sounding, w_sounding_nxt;
  logic                     r_busy, w_busy_nxt;
  logic                     r_done, w_done_nxt;

  logic [SONG_W-1:0]        w_rom_song;
  logic [CNT_W-1:0]         w_track;
  note_t                    w_entry;
  logic [DUR_W-1:0]         w_note_ticks;
  logic [DUR_W-1:0]         w_dur_dec;
  logic                     w_in_timed;
  logic                     w_run;
  logic                     w_tick;

  // A start looks up the new song so an empty track is caught before FETCH.
  assign w_rom_song = i_start ? i_song_sel : r_song;

  song_rom #(
    .SONG_W (SONG_W),
    .CNT_W  (CNT_W)
  ) u_song_rom (
    .i_song    (w_rom_song),
    .i_cnt     (r_idx),
    .o_track_c (w_track),
    .o_entry_c (w_entry)
  );

  assign w_note_ticks = DUR_W'(note_units(w_entry.length, w_entry.full_note)) * DUR_W'(UNIT_TICKS);
  assign w_dur_dec    = r_dur - DUR_W'(1);
  assign w_in_timed   = (r_state == ST_PLAY) || (r_state == ST_GAP);
  assign w_run        = w_in_timed && !i_pause;
  assign w_tick       = w_run && (r_presc == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_presc    <= '0;
      r_dur      <= '0;
      r_song     <= '0;
      r_idx      <= '0;
      r_octave   <= '0;
      r_note     <= '0;
      r_sounding <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_presc    <= w_presc_nxt;
      r_dur      <= w_dur_nxt;
      r_song     <= w_song_nxt;
      r_idx      <= w_idx_nxt;
      r_octave   <= w_octave_nxt;
      r_note     <= w_note_nxt;
      r_sounding <= w_sounding_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_presc_nxt  = r_presc;
    w_dur_nxt    = r_dur;
    w_song_nxt   = r_song;
    w_idx_nxt    = r_idx;
    w_octave_nxt = r_octave;
    w_note_nxt   = r_note;
    w_done_nxt   = 1'b0;

    if (i_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (i_start) begin
      w_song_nxt  = i_song_sel;
      w_idx_nxt   = '0;
      w_presc_nxt = '0;
      if (w_track == '0) begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end else begin
        w_state_nxt = ST_FETCH;
      end
    end else begin
      case (r_state)
        ST_FETCH: begin
          w_octave_nxt = w_entry.octave;
          w_note_nxt   = w_entry.note;
          w_dur_nxt    = w_note_ticks;
          w_presc_nxt  = '0;
          w_state_nxt  = ST_PLAY;
        end
        ST_PLAY, ST_GAP: begin
          if (w_run) begin
            w_presc_nxt = w_tick ? '0 : r_presc + PRE_W'(1);
            if (w_tick) begin
              w_dur_nxt = w_dur_dec;
              if (r_state == ST_PLAY && w_dur_dec == DUR_W'(GAP_TICKS)) begin
                w_state_nxt = PLAY_END;
              end else if (r_state == ST_GAP && w_dur_dec == '0) begin
                w_state_nxt = ST_ADV;
              end
            end
          end
        end
        ST_ADV: begin
          if (r_idx == w_track - CNT_W'(1)) begin
            if (i_loop_en) begin
              w_idx_nxt   = '0;
              w_state_nxt = ST_FETCH;
            end else begin
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_idx_nxt   = r_idx + CNT_W'(1);
            w_state_nxt = ST_FETCH;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end

    // A pause observed in PLAY silences the tone from the next cycle on.
    w_sounding_nxt = (w_state_nxt == ST_PLAY) && !(w_in_timed && i_pause);
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
  end

  assign o_octave   = r_octave;
  assign o_note     = r_note;
  assign o_sounding = r_sounding;
  assign o_note_idx = r_idx;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule
